// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and UART transmit handshake shared by the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_transmit;
    logic                 tx_ready;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_transmit
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_transmit
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional stalled-lock revocation is built when UART_ARB_LOCK_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    parameter int unsigned LOCK_TIMEOUT = 50000,
`endif
    localparam int unsigned IDW = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_tx_arbiter_if.master   bus,
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    output logic                lock_timeout,
`endif
    output logic [IDW-1:0]      grant_id,
    output logic                locked
);

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    int unsigned    sidx;
    logic           found;
    logic           accept;
    logic           tmo_fire;

    // Modulo-NUM_REQ increment; NUM_REQ need not be a power of two.
    function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
        return (x == IDW'(NUM_REQ - 1)) ? '0 : x + IDW'(1);
    endfunction

    // Ordered search from the rr pointer; a held lock narrows eligibility to grant_id.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        sidx  = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sidx = 32'(rr_ptr) + k;
            if (sidx >= NUM_REQ) begin
                sidx = sidx - NUM_REQ;
            end
            cand = IDW'(sidx);
            if (!found && bus.req_valid[cand] && (!locked || cand == grant_id)) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // GUARD skips the cycle where the UART's registered tx_ready has not yet fallen.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.req_ready = '0;
        case (state)
            ST_ARB: begin
                if (bus.tx_ready && found) begin
                    accept        = 1'b1;
                    bus.req_ready = NUM_REQ'(1) << win;
                    state_nxt     = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_GUARD;
            ST_GUARD: state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.tx_ready) begin
                    state_nxt = ST_ARB;
                end
            end
            default:  state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.tx_data     <= 8'h00;
            bus.tx_transmit <= 1'b0;
            grant_id        <= '0;
            locked          <= 1'b0;
            rr_ptr          <= '0;
        end else begin
            bus.tx_transmit <= accept;
            if (accept) begin
                bus.tx_data <= bus.req_data[{win, 3'b000} +: 8];
                grant_id    <= win;
                if (bus.req_last[win]) begin
                    locked <= 1'b0;
                    rr_ptr <= inc_mod(win);
                end else begin
                    locked <= 1'b1;
                end
            end else if (tmo_fire) begin
                locked <= 1'b0;
                rr_ptr <= inc_mod(grant_id);
            end
        end
    end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_idle;

    // Counts cycles the lock owner sits idle in ARB; any acceptance restarts it.
    assign tmo_idle = locked && (state == ST_ARB) && !bus.req_valid[grant_id];
    assign tmo_fire = tmo_idle && (tmo_cnt == 16'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt      <= 16'd0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= tmo_fire;
            if (accept || tmo_fire) begin
                tmo_cnt <= 16'd0;
            end else if (tmo_idle) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, a simple UART model, issue log.
module tb_uart_tx_arbiter;

    localparam int unsigned NR    = 4;
    localparam int unsigned FRAME = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
    logic [1:0] grant_id;
    logic       locked;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    logic       lock_timeout;
`endif

    uart_tx_arbiter #(.NUM_REQ(NR)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
`ifdef UART_ARB_LOCK_TIMEOUT_EN
        .lock_timeout (lock_timeout),
`endif
        .grant_id     (grant_id),
        .locked       (locked)
    );

    // UART model: busy for FRAME cycles after a transmit; not reset by reset_n.
    logic u_ready = 1'b1;
    int   u_cnt   = 0;
    assign bus.tx_ready = u_ready;
    always @(posedge clk) begin
        if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) u_ready <= 1'b1;
        end else if (bus.tx_transmit && u_ready) begin
            u_ready <= 1'b0;
            u_cnt   <= FRAME;
        end
    end

    // Byte sources
    logic [7:0]    src_dat  [NR][16];
    logic          src_last [NR][16];
    int            wr_p     [NR] = '{default: 0};
    logic          gate     [NR] = '{default: 1'b0};
    logic [NR-1:0]   rv = '0;
    logic [8*NR-1:0] rd = '0;
    logic [NR-1:0]   rl = '0;
    assign bus.req_valid = rv;
    assign bus.req_data  = rd;
    assign bus.req_last  = rl;

    // Monitor state
    int         acc_cnt [NR] = '{default: 0};
    logic [7:0] iss_dat [$];
    int         iss_id  [$];
    int         viol     = 0;
    logic       prev_acc = 1'b0;
    logic       prev_tx  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_dat[r][wr_p[r]]  = d;
        src_last[r][wr_p[r]] = l;
        wr_p[r]++;
    endtask

    task automatic wait_iss(input int n, input string tag);
        int b;
        b = 0;
        while (iss_dat.size() < n && b < 400) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk(tag, iss_dat.size(), n);
    endtask

    task automatic idle();
        repeat (FRAME + 6) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        iss_dat.delete();
        iss_id.delete();
    endtask

    // Source driver: present the next unaccepted byte of each requester unless gated.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (!gate[i] && acc_cnt[i] < wr_p[i]) begin
                    rv[i]        = 1'b1;
                    rd[8*i +: 8] = src_dat[i][acc_cnt[i]];
                    rl[i]        = src_last[i][acc_cnt[i]];
                end else begin
                    rv[i] = 1'b0;
                end
            end
        end
    end

    // Protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        int nb;
        nb = 0;
        for (int i = 0; i < NR; i++) begin
            if (bus.req_ready[i]) begin
                acc_cnt[i]++;
                nb++;
            end
        end
        if (nb > 1) viol++;
        if (nb != 0 && !bus.tx_ready) viol++;
        if (bus.tx_transmit) begin
            iss_dat.push_back(bus.tx_data);
            iss_id.push_back(32'(grant_id));
            if (!prev_acc || prev_tx || !bus.tx_ready) viol++;
        end else if (prev_acc && reset_n) begin
            viol++;
        end
        prev_acc = (nb != 0);
        prev_tx  = bus.tx_transmit;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp2_d [5] = '{'h10, 'h11, 'h12, 'h13, 'h14};
        int exp2_i [5] = '{0, 1, 2, 3, 0};
        int exp3_d [7] = '{'hA0, 'hA1, 'hA2, 'hC0, 'hB0, 'hB1, 'hB2};
        int exp3_i [7] = '{2, 2, 2, 3, 1, 1, 1};
        int a0;

        // Reset values
        #2 reset_n = 1'b0;
        #10;
        chk("rst_tx_transmit", 32'(bus.tx_transmit), 0);
        chk("rst_req_ready",   32'(bus.req_ready), 0);
        chk("rst_tx_data",     32'(bus.tx_data), 0);
        chk("rst_grant_id",    32'(grant_id), 0);
        chk("rst_locked",      32'(locked), 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single byte from requester 0
        push(0, 8'h41, 1'b1);
        wait_iss(1, "t1_issue_cnt");
        chk("t1_data",   32'(iss_dat[0]), 'h41);
        chk("t1_id",     iss_id[0], 0);
        chk("t1_acc0",   acc_cnt[0], 1);
        chk("t1_locked", 32'(locked), 0);
        idle();

        // Pointer moved to 1: requester 1 beats requester 0
        push(0, 8'h50, 1'b1);
        push(1, 8'h51, 1'b1);
        wait_iss(3, "t1b_issue_cnt");
        chk("t1b_first_id",  iss_id[1], 1);
        chk("t1b_first_dat", 32'(iss_dat[1]), 'h51);
        chk("t1b_second_dat", 32'(iss_dat[2]), 'h50);
        idle();

        // All four valid after reset: order 0,1,2,3,0
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        clear_log();
        push(0, 8'h10, 1'b1);
        push(1, 8'h11, 1'b1);
        push(2, 8'h12, 1'b1);
        push(3, 8'h13, 1'b1);
        push(0, 8'h14, 1'b1);
        wait_iss(5, "t2_issue_cnt");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_dat%0d", k), 32'(iss_dat[k]), exp2_d[k]);
            chk($sformatf("t2_id%0d", k), iss_id[k], exp2_i[k]);
        end
        idle();

        // Three-byte packet from requester 2 holds off requester 1
        clear_log();
        push(2, 8'hA0, 1'b0);
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b1);
        wait_iss(1, "t3_first_cnt");
        chk("t3_locked", 32'(locked), 1);
        push(1, 8'hB0, 1'b1);
        push(1, 8'hB1, 1'b1);
        push(1, 8'hB2, 1'b1);
        push(3, 8'hC0, 1'b1);
        wait_iss(7, "t3_issue_cnt");
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t3_dat%0d", k), 32'(iss_dat[k]), exp3_d[k]);
            chk($sformatf("t3_id%0d", k), iss_id[k], exp3_i[k]);
        end
        idle();

        // Locked requester 1 stalls; requester 0 must wait
        clear_log();
        push(1, 8'hD0, 1'b0);
        push(1, 8'hD1, 1'b1);
        wait_iss(1, "t4_first_cnt");
        gate[1] = 1'b1;
        push(0, 8'hE0, 1'b1);
        a0 = acc_cnt[0];
        repeat (FRAME + 14) @(posedge clk);
        #1;
        chk("t4_blocked_acc0", acc_cnt[0] - a0, 0);
        chk("t4_locked",       32'(locked), 1);
        chk("t4_grant",        32'(grant_id), 1);
        gate[1] = 1'b0;
        wait_iss(3, "t4_issue_cnt");
        chk("t4_dat1", 32'(iss_dat[1]), 'hD1);
        chk("t4_dat2", 32'(iss_dat[2]), 'hE0);
        chk("t4_id2",  iss_id[2], 0);
        idle();

        // Reset while the arbiter is draining a locked packet
        clear_log();
        push(2, 8'h77, 1'b0);
        push(2, 8'h78, 1'b1);
        wait_iss(1, "t5_first_cnt");
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("t5_rst_tx_transmit", 32'(bus.tx_transmit), 0);
        chk("t5_rst_req_ready",   32'(bus.req_ready), 0);
        chk("t5_rst_tx_data",     32'(bus.tx_data), 0);
        chk("t5_rst_grant_id",    32'(grant_id), 0);
        chk("t5_rst_locked",      32'(locked), 0);
        @(negedge clk) reset_n = 1'b1;
        clear_log();
        push(3, 8'h99, 1'b1);
        push(1, 8'h88, 1'b1);
        wait_iss(3, "t5_issue_cnt");
        chk("t5_dat0", 32'(iss_dat[0]), 'h88);
        chk("t5_dat1", 32'(iss_dat[1]), 'h78);
        chk("t5_dat2", 32'(iss_dat[2]), 'h99);
        idle();

        chk("protocol_violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
